// File: rtl/wt_step_scheduler_if.sv
// wt_step_scheduler_if: control/status bundle between the step scheduler and its stages.
//   master: drives run, clr_err, done_in; observes the scheduler outputs.
//   slave : the scheduler itself (receives run/clr_err/done_in, drives the rest).
interface wt_step_scheduler_if #(
    parameter int TIME_W = 32
);
    logic              run;
    logic              clr_err;
    logic              done_in;
    logic              sta;
    logic              sta_d5;
    logic              sta_d7;
    logic              sta_d8;
    logic              sta_d10;
    logic [TIME_W-1:0] sim_time;
    logic              rd_en;
    logic              exchange_sig;
    logic              busy;
    logic              overrun;
    logic              timeout;

    modport master (
        output run, clr_err, done_in,
        input  sta, sta_d5, sta_d7, sta_d8, sta_d10, sim_time, rd_en, exchange_sig, busy, overrun, timeout
    );

    modport slave (
        input  run, clr_err, done_in,
        output sta, sta_d5, sta_d7, sta_d8, sta_d10, sim_time, rd_en, exchange_sig, busy, overrun, timeout
    );
endinterface

// File: rtl/wt_step_scheduler.sv
// wt_step_scheduler: per-timestep sequencer for the wind-turbine control subsystem.
//   clk, rst_user   : clock and asynchronous active-high reset
//   bus (slave)     : run / clr_err / done_in in; sta + delayed taps, sim_time,
//                     rd_en burst, exchange_sig, busy and sticky overrun/timeout out
module wt_step_scheduler #(
    parameter int STEP_CYCLES  = 64,
    parameter int N_WORDS      = 8,
    parameter int EXCH_DELAY   = 3,
    parameter int DONE_TIMEOUT = 40,
    parameter int TIME_W       = 32
) (
    input  logic               clk,
    input  logic               rst_user,
    wt_step_scheduler_if.slave bus
);
    typedef enum logic [2:0] {IDLE, COMPUTE, DELAY, DRAIN, WAIT} state_t;

    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [15:0]       sc_q, sc_d;
    logic [TIME_W-1:0] time_q, time_d;
    logic [9:0]        sh_q, sh_d;
    logic [1:0]        xs_q, xs_d;
    logic              to_q, to_d;
    logic              ov_q, ov_d;
    logic              bnd, idle_like;
    logic              sta, rd_en, busy, first, to_set, ov_set;

    assign bnd       = bus.run && cnt_q == '0;
    assign idle_like = state_q == IDLE || state_q == WAIT;

    always_ff @(posedge clk or posedge rst_user) begin
        if (rst_user) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // sc_q restarts on every state change, so it serves as watchdog, delay and burst counter
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bnd ? COMPUTE : IDLE;
            COMPUTE: state_d = bus.done_in ? DELAY : sc_q == 16'(DONE_TIMEOUT - 1) ? WAIT : COMPUTE;
            DELAY:   state_d = sc_q == 16'(EXCH_DELAY - 1) ? DRAIN : DELAY;
            DRAIN:   state_d = sc_q == 16'(N_WORDS - 1) ? WAIT : DRAIN;
            WAIT:    state_d = bnd ? COMPUTE : bus.run ? WAIT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // sta is combinational from the boundary; gate it so it stays low during reset
    always_comb begin
        sta    = bnd && idle_like && !rst_user;
        rd_en  = state_q == DRAIN;
        busy   = !idle_like;
        first  = state_q == DRAIN && sc_q == '0;
        to_set = state_q == COMPUTE && !bus.done_in && sc_q == 16'(DONE_TIMEOUT - 1);
        ov_set = bnd && !idle_like;
    end

    always_comb begin
        cnt_d  = !bus.run ? '0 : cnt_q == 16'(STEP_CYCLES - 1) ? '0 : cnt_q + 16'd1;
        sc_d   = state_d != state_q ? '0 : sc_q + 16'd1;
        time_d = sta ? time_q + TIME_W'(1) : time_q;
        sh_d   = {sh_q[8:0], sta};
        xs_d   = {xs_q[0], first};
        to_d   = to_set || (to_q && !bus.clr_err);
        ov_d   = ov_set || (ov_q && !bus.clr_err);
    end

    always_ff @(posedge clk or posedge rst_user) begin
        if (rst_user) begin
            cnt_q  <= '0;
            sc_q   <= '0;
            time_q <= '0;
            sh_q   <= '0;
            xs_q   <= '0;
            to_q   <= 1'b0;
            ov_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sc_q   <= sc_d;
            time_q <= time_d;
            sh_q   <= sh_d;
            xs_q   <= xs_d;
            to_q   <= to_d;
            ov_q   <= ov_d;
        end
    end

    assign bus.sta          = sta;
    assign bus.rd_en        = rd_en;
    assign bus.busy         = busy;
    assign bus.sta_d5       = sh_q[4];
    assign bus.sta_d7       = sh_q[6];
    assign bus.sta_d8       = sh_q[7];
    assign bus.sta_d10      = sh_q[9];
    assign bus.sim_time     = time_q;
    assign bus.exchange_sig = xs_q[1];
    assign bus.timeout      = to_q;
    assign bus.overrun      = ov_q;
endmodule

// File: tb/tb_wt_step_scheduler.sv
// tb_wt_step_scheduler: scoreboard bench for two scheduler configurations
// (defaults, and a short-step 4-bit-time variant for overrun and wrap).
module tb_wt_step_scheduler;
    localparam int E = 3;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   err = 0;
    int   chk = 0;

    logic run_v [2];
    logic done_v [2];
    logic clr_v [2];
    logic [9:0]  ob [2];
    logic [31:0] st [2];

    int          q [20][$];
    logic [31:0] qtv [2][$];
    logic [31:0] et [2];
    logic [31:0] msk [2] = '{32'hFFFF_FFFF, 32'h0000_000F};
    int          S [2]   = '{64, 24};
    int          DT [2]  = '{40, 16};
    bit          tof [2];
    bit          ovf [2];
    string       nms [10] = '{"sta", "sta_d5", "sta_d7", "sta_d8", "sta_d10", "rd_en", "exchange_sig", "timeout", "overrun", "busy"};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wt_step_scheduler_if #(.TIME_W(32)) ifa ();
    wt_step_scheduler_if #(.TIME_W(4))  ifb ();

    assign ifa.run = run_v[0];
    assign ifa.done_in = done_v[0];
    assign ifa.clr_err = clr_v[0];
    assign ifb.run = run_v[1];
    assign ifb.done_in = done_v[1];
    assign ifb.clr_err = clr_v[1];

    assign ob[0] = {ifa.busy, ifa.overrun, ifa.timeout, ifa.exchange_sig, ifa.rd_en,
                    ifa.sta_d10, ifa.sta_d8, ifa.sta_d7, ifa.sta_d5, ifa.sta};
    assign ob[1] = {ifb.busy, ifb.overrun, ifb.timeout, ifb.exchange_sig, ifb.rd_en,
                    ifb.sta_d10, ifb.sta_d8, ifb.sta_d7, ifb.sta_d5, ifb.sta};
    assign st[0] = ifa.sim_time;
    assign st[1] = {28'd0, ifb.sim_time};

    wt_step_scheduler dut_a (.clk(clk), .rst_user(rst), .bus(ifa));

    wt_step_scheduler #(.STEP_CYCLES(24), .DONE_TIMEOUT(16), .TIME_W(4)) dut_b (
        .clk(clk), .rst_user(rst), .bus(ifb));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(int i, int k, int c);
        q[i * 10 + k].push_back(c);
    endtask

    task automatic check(string n, logic [31:0] a, logic [31:0] r);
        chk++;
        if (a !== r) begin
            err++;
            $display("FAIL %s: got %0h, required %0h", n, a, r);
        end
    endtask

    task automatic flush();
        for (int j = 0; j < 20; j++) q[j].delete();
        for (int i = 0; i < 2; i++) begin
            qtv[i].delete();
            et[i] = '0;
            tof[i] = 1'b0;
            ovf[i] = 1'b0;
        end
    endtask

    // pulse outputs pop one expected cycle per high cycle; level outputs pop one per change
    task automatic monitor();
        logic [9:0]  pv [2];
        int          tc [2];
        logic [31:0] tx [2];
        int          e;
        for (int i = 0; i < 2; i++) begin
            pv[i] = '0;
            tc[i] = -1;
            tx[i] = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    pv[i] = '0;
                    tc[i] = -1;
                end else begin
                    for (int k = 0; k < 10; k++) begin
                        if (k < 7 ? ob[i][k] == 1'b1 : ob[i][k] != pv[i][k]) begin
                            chk++;
                            if (q[i * 10 + k].size() == 0) begin
                                err++;
                                $display("FAIL inst%0d %s: event at cycle %0d, none expected", i, nms[k], cyc);
                            end else begin
                                e = q[i * 10 + k].pop_front();
                                if (e != cyc) begin
                                    err++;
                                    $display("FAIL inst%0d %s: event at cycle %0d, required cycle %0d", i, nms[k], cyc, e);
                                end
                                if (k == 0 && qtv[i].size() > 0) begin
                                    tc[i] = cyc + 1;
                                    tx[i] = qtv[i].pop_front();
                                end
                            end
                        end
                    end
                    if (tc[i] == cyc) begin
                        chk++;
                        if (st[i] !== tx[i]) begin
                            err++;
                            $display("FAIL inst%0d sim_time: got %0d at cycle %0d, required %0d", i, st[i], cyc, tx[i]);
                        end
                        tc[i] = -1;
                    end
                    pv[i] = ob[i];
                end
            end
        end
    endtask

    // Reference: boundaries every S cycles from the cycle run rises; a step is busy until its
    // burst ends (or the watchdog expires); any boundary up to that point is an overrun.
    task automatic play(int i, int n, bit dir);
        int t, b, d, cc, dr, en, l, tgt, cm;
        bit to;
        run_v[i] = 1'b1;
        t = cyc;
        for (int k = 0; k < n; k++) begin
            et[i] = (et[i] + 32'd1) & msk[i];
            push(i, 0, t);
            qtv[i].push_back(et[i]);
            push(i, 1, t + 5);
            push(i, 2, t + 7);
            push(i, 3, t + 8);
            push(i, 4, t + 10);
            push(i, 9, t + 1);
            to = dir ? (k == 1) : ($urandom_range(0, 3) == 0);
            l = (dir && k == 0) ? (i == 0 ? 20 : 15) : int'($urandom_range(1, DT[i]));
            d = -1;
            cc = -1;
            if (to) begin
                en = t + DT[i];
                cm = dir ? 2 : int'($urandom_range(0, 2));
                if (!tof[i]) push(i, 7, en + 1);
                tof[i] = 1'b1;
                if (cm != 0) begin
                    cc = cm == 1 ? en : en + 2;
                    if (cm == 2) begin
                        push(i, 7, cc + 1);
                        tof[i] = 1'b0;
                    end
                    if (ovf[i]) push(i, 8, cc + 1);
                    ovf[i] = 1'b0;
                end
            end else begin
                d = t + l;
                en = d + E + N;
                for (int c = d + E + 1; c <= en; c++) push(i, 5, c);
                push(i, 6, d + E + 3);
            end
            push(i, 9, en + 1);
            b = t + S[i];
            if (k == n - 1) begin
                dr = d >= 0 ? (d + E + 3 < b ? d + E + 3 : b - 1) : int'($urandom_range(t + 1, b - 1));
                tgt = (cc > en ? cc : en) + 3;
            end else begin
                dr = -1;
                while (b <= en) begin
                    if (!ovf[i]) push(i, 8, b + 1);
                    ovf[i] = 1'b1;
                    b += S[i];
                end
                tgt = b;
            end
            while (cyc < tgt) begin
                tick();
                done_v[i] = cyc == d;
                clr_v[i] = cyc == cc;
                if (cyc == dr) run_v[i] = 1'b0;
            end
            t = b;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t, d;
        for (int i = 0; i < 2; i++) begin
            run_v[i] = 1'b0;
            done_v[i] = 1'b0;
            clr_v[i] = 1'b0;
        end
        flush();
        fork
            monitor();
        join_none
        repeat (3) tick();
        check("reset outputs a", 32'(ob[0]), 32'd0);
        check("reset outputs b", 32'(ob[1]), 32'd0);
        check("reset sim_time a", st[0], 32'd0);
        check("reset sim_time b", st[1], 32'd0);
        rst = 1'b0;
        repeat (2) tick();
        play(0, 3, 1'b1);
        repeat (4) tick();
        play(0, 5, 1'b0);
        repeat (3) tick();
        run_v[0] = 1'b1;
        t = cyc;
        et[0] = et[0] + 32'd1;
        push(0, 0, t);
        qtv[0].push_back(et[0]);
        push(0, 1, t + 5);
        push(0, 2, t + 7);
        push(0, 3, t + 8);
        push(0, 4, t + 10);
        push(0, 9, t + 1);
        d = t + 6;
        for (int c = d + E + 1; c <= d + E + N; c++) push(0, 5, c);
        push(0, 6, d + E + 3);
        while (cyc < d + E + 4) begin
            tick();
            done_v[0] = cyc == d;
        end
        #2;
        check("rd_en before async reset", 32'(ifa.rd_en), 32'd1);
        rst = 1'b1;
        flush();
        #1;
        check("outputs during async reset", 32'(ob[0]), 32'd0);
        check("sim_time during async reset", st[0], 32'd0);
        run_v[0] = 1'b0;
        tick();
        rst = 1'b0;
        repeat (2) tick();
        play(0, 2, 1'b0);
        play(1, 3, 1'b1);
        repeat (2) tick();
        play(1, 20, 1'b0);
        play(1, 6, 1'b0);
        repeat (5) tick();
        for (int j = 0; j < 20; j++) begin
            chk++;
            if (q[j].size() != 0) begin
                err++;
                $display("FAIL inst%0d %s: %0d expected events never seen, first at cycle %0d",
                         j / 10, nms[j % 10], q[j].size(), q[j][0]);
            end
        end
        $display("Result: errors=%0d of %0d checks", err, chk);
        $finish;
    end
endmodule
